// File: rtl/synapse_pkg.sv
// Shared constants and FSM encoding for the synapse weight loader.
package synapse_pkg;

   localparam int W_BITS = 2;
   localparam int DATA_W = 8;
   localparam int WPB    = DATA_W / W_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/synapse_gate.sv
// Per-synapse gate: passes the weight when the synapse spikes, else zero.
module synapse_gate
   import synapse_pkg::*;
(
   input  logic              spike,
   input  logic [W_BITS-1:0] weight,
   output logic [W_BITS-1:0] wx
);

   assign wx = weight & {W_BITS{spike}};

endmodule

// File: rtl/synapse_weight_loader.sv
// Weight frame loader and spike-gated wx bus driver.
// Build option: SHADOW_WEIGHTS_EN double-buffers weights, swapping on commit.
module synapse_weight_loader
   import synapse_pkg::*;
#(
   parameter int N_SYN = 32
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_start,
   input  logic [DATA_W-1:0]       load_data,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [N_SYN-1:0]        spike_in,
   output logic [N_SYN*W_BITS-1:0] wx_out,
   output logic                    weights_loaded,
   output logic                    load_busy
);

   localparam int NB = N_SYN / WPB;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int WW = N_SYN * W_BITS;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] byte_cnt;
   logic [CW-1:0] byte_cnt_n;
   logic          accept;
   logic          last;
   logic          commit;
   logic [WW-1:0] w_active;
   logic [WW-1:0] gated;

   assign load_ready = (state == LOAD);
   assign load_busy  = (state != IDLE);
   // A restart wins over a byte arriving in the same cycle
   assign accept = load_valid & load_ready & ~load_start;
   assign last   = (byte_cnt == CW'(NB - 1));
   assign commit = (state == COMMIT) & ~load_start;

   always_comb begin
      state_n    = state;
      byte_cnt_n = byte_cnt;
      if (load_start) begin
         state_n    = LOAD;
         byte_cnt_n = '0;
      end else begin
         case (state)
            IDLE: ;
            LOAD: begin
               if (accept) begin
                  if (last) begin
                     state_n    = COMMIT;
                     byte_cnt_n = '0;
                  end else begin
                     byte_cnt_n = byte_cnt + 1'b1;
                  end
               end
            end
            COMMIT: begin
               state_n    = IDLE;
               byte_cnt_n = '0;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         byte_cnt       <= '0;
         weights_loaded <= 1'b0;
      end else begin
         state    <= state_n;
         byte_cnt <= byte_cnt_n;
         if (load_start) begin
            weights_loaded <= 1'b0;
         end else if (commit) begin
            weights_loaded <= 1'b1;
         end
      end
   end

`ifdef SHADOW_WEIGHTS_EN
   logic [WW-1:0] w_shadow;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_shadow <= '0;
         w_active <= '0;
      end else begin
         if (accept) begin
            w_shadow[int'(byte_cnt)*DATA_W +: DATA_W] <= load_data;
         end
         if (commit) begin
            w_active <= w_shadow;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_active <= '0;
      end else if (accept) begin
         w_active[int'(byte_cnt)*DATA_W +: DATA_W] <= load_data;
      end
   end
`endif

   for (genvar j = 0; j < N_SYN; j++) begin : g_gate
      synapse_gate u_gate (
         .spike  (spike_in[j]),
         .weight (w_active[j*W_BITS +: W_BITS]),
         .wx     (gated[j*W_BITS +: W_BITS])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wx_out <= '0;
      end else begin
         wx_out <= gated;
      end
   end

endmodule

// File: tb/tb_synapse_weight_loader.sv
// Randomized and directed checks of synapse_weight_loader against a frame-level model.
module tb_synapse_weight_loader;

   logic        clk;
   logic        rst_n;
   logic        load_start;
   logic [7:0]  load_data;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] spike_in;
   logic [63:0] wx_out;
   logic        weights_loaded;
   logic        load_busy;

   synapse_weight_loader #(.N_SYN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_start     (load_start),
      .load_data      (load_data),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .spike_in       (spike_in),
      .wx_out         (wx_out),
      .weights_loaded (weights_loaded),
      .load_busy      (load_busy)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;
   int acc_cnt = 0;

   // model state
   logic [63:0] act_w  = '0;
   logic [63:0] shad_w = '0;
   bit          in_frame = 0;
   bit          pend = 0;
   int          nbytes = 0;
   bit          m_loaded = 0;
   logic [63:0] m_wx = '0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Frame-level model: a frame is 8 accepted bytes followed by one commit cycle
   initial begin
      logic [63:0] e;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            act_w = '0; shad_w = '0; in_frame = 0; pend = 0;
            nbytes = 0; m_loaded = 0; m_wx = '0;
         end else begin
            e = '0;
            for (int j = 0; j < 32; j++)
               if (spike_in[j]) e[2*j +: 2] = act_w[2*j +: 2];
            if (load_valid && load_ready && !load_start) acc_cnt++;
            if (load_start) begin
               in_frame = 1; nbytes = 0; pend = 0; m_loaded = 0;
            end else if (pend) begin
               pend = 0;
               m_loaded = 1;
`ifdef SHADOW_WEIGHTS_EN
               act_w = shad_w;
`endif
            end else if (in_frame && load_valid) begin
`ifdef SHADOW_WEIGHTS_EN
               shad_w[nbytes*8 +: 8] = load_data;
`else
               act_w[nbytes*8 +: 8] = load_data;
`endif
               nbytes++;
               if (nbytes == 8) begin
                  in_frame = 0; pend = 1; nbytes = 0;
               end
            end
            m_wx = e;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("wx_out", wx_out, m_wx);
            check("load_ready", 64'(load_ready), 64'(in_frame));
            check("load_busy", 64'(load_busy), 64'(in_frame | pend));
            check("weights_loaded", 64'(weights_loaded), 64'(m_loaded));
         end
      end
   end

   task automatic load_frame(input logic [7:0] d);
      load_start = 1; cyc();
      load_start = 0; load_valid = 1; load_data = d;
      repeat (8) cyc();
      load_valid = 0; cyc(); cyc();
   endtask

   initial begin
      rst_n = 0; load_start = 0; load_valid = 0; load_data = '0;
      spike_in = '1;
      cyc();
      // 1 reset
      check("t1_wx", wx_out, 64'h0);
      check("t1_ready", 64'(load_ready), 64'h0);
      check("t1_loaded", 64'(weights_loaded), 64'h0);
      rst_n = 1; chk_en = 1;
      cyc();

      // 2 back-to-back frame of E4
      load_start = 1; cyc();
      load_start = 0; load_valid = 1; load_data = 8'hE4;
      for (int i = 0; i < 8; i++) begin
         check("t2_ready", 64'(load_ready), 64'h1);
         cyc();
      end
      load_valid = 0; cyc();
      check("t2_loaded", 64'(weights_loaded), 64'h1);
      cyc();
      check("t2_wx", wx_out, 64'hE4E4_E4E4_E4E4_E4E4);

      // 3 single-synapse gating
      spike_in = 32'h0000_0001; cyc();
      check("t3_syn0", wx_out, 64'h0);
      spike_in = 32'h0000_0002; cyc();
      check("t3_syn1", wx_out, 64'h4);

      // 4 throttled load
      spike_in = '1; acc_cnt = 0;
      load_start = 1; cyc();
      load_start = 0;
      for (int k = 0; k < 60 && !weights_loaded; k++) begin
         load_valid = (k % 2 == 0);
         load_data = 8'($urandom);
         cyc();
      end
      load_valid = 0;
      check("t4_done", 64'(weights_loaded), 64'h1);
      check("t4_accepts", 64'(acc_cnt), 64'd8);

      // 5 abort then full frame
      load_frame(8'hE4);
      spike_in = '1;
      load_start = 1; cyc();
      load_start = 0; load_valid = 1; load_data = 8'hFF;
      repeat (3) cyc();
      load_valid = 0; cyc();
`ifdef SHADOW_WEIGHTS_EN
      check("t5_mid", wx_out, 64'hE4E4_E4E4_E4E4_E4E4);
`else
      check("t5_mid", wx_out, 64'hE4E4_E4E4_E4FF_FFFF);
`endif
      load_start = 1; cyc();
      load_start = 0; load_valid = 1; load_data = 8'h55;
      for (int i = 0; i < 8; i++) begin
`ifdef SHADOW_WEIGHTS_EN
         check("t5_hold", wx_out, 64'hE4E4_E4E4_E4E4_E4E4);
`endif
         cyc();
      end
      load_valid = 0; cyc(); cyc();
      check("t5_final", wx_out, 64'h5555_5555_5555_5555);

      // 6 reset mid-load
      load_start = 1; cyc();
      load_start = 0; load_valid = 1; load_data = 8'($urandom);
      repeat (4) cyc();
      rst_n = 0; cyc();
      check("t6_ready", 64'(load_ready), 64'h0);
      check("t6_busy", 64'(load_busy), 64'h0);
      check("t6_wx", wx_out, 64'h0);
      rst_n = 1; load_valid = 0; cyc();
      check("t6_wts", wx_out, 64'h0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         load_start = ($urandom_range(0, 19) == 0);
         load_valid = 1'($urandom_range(0, 1));
         load_data  = 8'($urandom);
         spike_in   = $urandom;
         cyc();
      end
      load_start = 0; load_valid = 0;
      repeat (4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
